complex_vector_alu: RTL and testbench

Parametrised, multi-lane complex fixed-point ALU for the EdgeNPU PE array. Each lane applies ADD, SUB, MUL, MULADD, MULSUB or MAX to packed complex operands {real, imag}. Arithmetic is portable RTL with no vendor DSP primitives: Q-format rounding and per-lane saturation flags. A fixed 3-stage pipeline carries a valid/ready handshake so the block sits directly between the operand fetch stage and the PE writeback FIFO.

---
 rtl/npu_pkg.sv | 19 +
 rtl/complex_alu_lane.sv | 133 +++++++++++++
 rtl/complex_vector_alu.sv | 73 +++++++
 tb/tb_complex_vector_alu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared EdgeNPU types: complex ALU opcodes, legality check and pipeline depth
package npu_pkg;

  typedef enum logic [2:0] {
    CPLX_ADD    = 3'b001,
    CPLX_SUB    = 3'b010,
    CPLX_MUL    = 3'b100,
    CPLX_MULADD = 3'b101,
    CPLX_MULSUB = 3'b110,
    CPLX_MAX    = 3'b111
  } cplx_op_e;

  localparam int CPLX_ALU_LATENCY = 3;

  function automatic logic is_legal_cplx_op(input logic [2:0] op);
    return (op != 3'b000) && (op != 3'b011);
  endfunction

endpackage

// File: rtl/complex_alu_lane.sv
// rtl/complex_alu_lane.sv - one complex lane: S1 operands, S2 products/sums/magnitudes, S3 round+saturate
module complex_alu_lane
  import npu_pkg::*;
#(
  parameter int W = 16,
  parameter int F = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_s1,
  input  logic           en_s2,
  input  logic           en_s3,
  input  logic [2:0]     opcode,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic [2*W-1:0] c,
  output logic [2*W-1:0] result,
  output logic           sat
);

  localparam int PW = 2*W + 1;
  localparam logic [PW-1:0] RND_U = (PW'(1) << F) >> 1;
  localparam logic signed [PW-1:0] RND = $signed(RND_U);

  function automatic logic signed [PW-1:0] sx(input logic [W-1:0] v);
    return {{(PW-W){v[W-1]}}, v};
  endfunction

  // returns {clipped, value}; in range when all bits above the W-bit sign agree
  function automatic logic [W:0] sat_w(input logic [PW:0] v);
    if (v[PW:W-1] == {(PW-W+2){v[PW]}})
      return {1'b0, v[W-1:0]};
    else
      return {1'b1, v[PW], {(W-1){~v[PW]}}};
  endfunction

  logic [2*W-1:0] a1, b1, c1, a2, b2, c2;
  logic [2:0]     op1, op2;
  logic signed [PW-1:0] pr2, pi2;
  logic [PW-1:0]  ma2, mb2;
  logic [W:0]     sr2, si2;

  logic signed [PW-1:0] ar, ai, br, bi;
  logic [W:0]     s_r, s_i;
  logic signed [PW-1:0] tr, ti, rr, ri;
  logic [PW:0]    cr_x, ci_x, sr_x, si_x, mr, mi;
  logic [W:0]     q_sr, q_si, q_mr, q_mi;
  logic [2*W-1:0] nxt_res;
  logic           nxt_sat;

  assign ar = sx(a1[2*W-1:W]);
  assign ai = sx(a1[W-1:0]);
  assign br = sx(b1[2*W-1:W]);
  assign bi = sx(b1[W-1:0]);

  assign s_r = (op1 == CPLX_SUB) ? {a1[2*W-1], a1[2*W-1:W]} - {b1[2*W-1], b1[2*W-1:W]}
                                 : {a1[2*W-1], a1[2*W-1:W]} + {b1[2*W-1], b1[2*W-1:W]};
  assign s_i = (op1 == CPLX_SUB) ? {a1[W-1], a1[W-1:0]} - {b1[W-1], b1[W-1:0]}
                                 : {a1[W-1], a1[W-1:0]} + {b1[W-1], b1[W-1:0]};

  assign tr = pr2 + RND;
  assign ti = pi2 + RND;
  assign rr = tr >>> F;
  assign ri = ti >>> F;

  assign cr_x = {{(PW+1-W){c2[2*W-1]}}, c2[2*W-1:W]};
  assign ci_x = {{(PW+1-W){c2[W-1]}}, c2[W-1:0]};
  assign sr_x = {{(PW-W){sr2[W]}}, sr2};
  assign si_x = {{(PW-W){si2[W]}}, si2};

  // C joins after rounding so its LSB lands on the integer grid of the result
  always_comb begin
    mr = {rr[PW-1], rr};
    mi = {ri[PW-1], ri};
    if (op2 == CPLX_MULADD) begin
      mr = mr + cr_x;
      mi = mi + ci_x;
    end else if (op2 == CPLX_MULSUB) begin
      mr = mr - cr_x;
      mi = mi - ci_x;
    end
  end

  assign q_sr = sat_w(sr_x);
  assign q_si = sat_w(si_x);
  assign q_mr = sat_w(mr);
  assign q_mi = sat_w(mi);

  always_comb begin
    nxt_res = '0;
    nxt_sat = 1'b0;
    case (op2)
      CPLX_ADD, CPLX_SUB: begin
        nxt_res = {q_sr[W-1:0], q_si[W-1:0]};
        nxt_sat = q_sr[W] | q_si[W];
      end
      CPLX_MUL, CPLX_MULADD, CPLX_MULSUB: begin
        nxt_res = {q_mr[W-1:0], q_mi[W-1:0]};
        nxt_sat = q_mr[W] | q_mi[W];
      end
      CPLX_MAX: nxt_res = (mb2 > ma2) ? b2 : a2;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= '0; b1 <= '0; c1 <= '0; op1 <= '0;
      a2 <= '0; b2 <= '0; c2 <= '0; op2 <= '0;
      pr2 <= '0; pi2 <= '0; ma2 <= '0; mb2 <= '0; sr2 <= '0; si2 <= '0;
      result <= '0;
      sat <= 1'b0;
    end else begin
      if (en_s1) begin
        a1 <= a; b1 <= b; c1 <= c; op1 <= opcode;
      end
      if (en_s2) begin
        a2 <= a1; b2 <= b1; c2 <= c1; op2 <= op1;
        pr2 <= ar*br - ai*bi;
        pi2 <= ar*bi + ai*br;
        ma2 <= ar*ar + ai*ai;
        mb2 <= br*br + bi*bi;
        sr2 <= s_r;
        si2 <= s_i;
      end
      if (en_s3) begin
        result <= nxt_res;
        sat    <= nxt_sat;
      end
    end
  end

endmodule

// File: rtl/complex_vector_alu.sv
// rtl/complex_vector_alu.sv - multi-lane complex ALU, 3-stage pipeline with one global advance enable
module complex_vector_alu
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int FRAC_BITS  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [2:0]                        opcode,
  input  logic [NUM_LANES*2*DATA_WIDTH-1:0] operand_a,
  input  logic [NUM_LANES*2*DATA_WIDTH-1:0] operand_b,
  input  logic [NUM_LANES*2*DATA_WIDTH-1:0] operand_c,
  output logic [NUM_LANES*2*DATA_WIDTH-1:0] result,
  output logic [NUM_LANES-1:0]              sat,
  output logic                              illegal_op,
  output logic                              out_valid,
  input  logic                              out_ready,
  input  logic                              clr_sat,
  output logic [NUM_LANES-1:0]              sat_sticky
);

  localparam int LW = 2*DATA_WIDTH;

  logic                        advance;
  logic [CPLX_ALU_LATENCY-1:0] vld, ill;

  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign out_valid  = vld[CPLX_ALU_LATENCY-1];
  assign illegal_op = ill[CPLX_ALU_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      ill <= '0;
    end else if (advance) begin
      vld <= {vld[CPLX_ALU_LATENCY-2:0], in_valid};
      ill <= {ill[CPLX_ALU_LATENCY-2:0], in_valid && !is_legal_cplx_op(opcode)};
    end
  end

  // the OR-in follows the clear so a coinciding handshake's flags survive
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_sticky <= '0;
    else
      sat_sticky <= (clr_sat ? '0 : sat_sticky) | ((out_valid && out_ready) ? sat : '0);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    complex_alu_lane #(
      .W (DATA_WIDTH),
      .F (FRAC_BITS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_s1  (advance),
      .en_s2  (advance),
      .en_s3  (advance),
      .opcode (opcode),
      .a      (operand_a[i*LW +: LW]),
      .b      (operand_b[i*LW +: LW]),
      .c      (operand_c[i*LW +: LW]),
      .result (result[i*LW +: LW]),
      .sat    (sat[i])
    );
  end

endmodule

// File: tb/tb_complex_vector_alu.sv
// tb/tb_complex_vector_alu.sv - directed and random-stall checks of complex_vector_alu against a behavioural model
module tb_complex_vector_alu;

  localparam int NL = 4;
  localparam int F  = 8;

  typedef struct packed {
    logic [127:0] r;
    logic [3:0]   s;
    logic         ill;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, clr_sat, illegal_op;
  logic [2:0]   opcode;
  logic [127:0] operand_a, operand_b, operand_c, result;
  logic [3:0]   sat, sat_sticky;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_rdy = 0;
  int   stall    = 0;
  exp_t q[$];
  logic [3:0] sticky_m = '0;

  complex_vector_alu #(.DATA_WIDTH(16), .NUM_LANES(NL), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
    .result(result), .sat(sat), .illegal_op(illegal_op), .out_valid(out_valid),
    .out_ready(out_ready), .clr_sat(clr_sat), .sat_sticky(sat_sticky)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] clip(input longint v);
    if (v > 32767)  return {1'b1, 16'h7fff};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [127:0] a, b, c);
    exp_t e;
    e.r = '0;
    e.s = '0;
    e.ill = (op == 3'b000) || (op == 3'b011);
    for (int i = 0; i < NL; i++) begin
      longint ar, ai, br, bi, cr, ci, vr, vi, ma, mb;
      logic [16:0] kr, ki;
      ar = longint'($signed(a[i*32+16 +: 16])); ai = longint'($signed(a[i*32 +: 16]));
      br = longint'($signed(b[i*32+16 +: 16])); bi = longint'($signed(b[i*32 +: 16]));
      cr = longint'($signed(c[i*32+16 +: 16])); ci = longint'($signed(c[i*32 +: 16]));
      vr = 0; vi = 0;
      case (op)
        3'b001: begin vr = ar + br; vi = ai + bi; end
        3'b010: begin vr = ar - br; vi = ai - bi; end
        3'b100, 3'b101, 3'b110: begin
          vr = (ar*br - ai*bi + (longint'(1) << (F-1))) >>> F;
          vi = (ar*bi + ai*br + (longint'(1) << (F-1))) >>> F;
          if (op == 3'b101) begin vr += cr; vi += ci; end
          if (op == 3'b110) begin vr -= cr; vi -= ci; end
        end
        default: ;
      endcase
      kr = clip(vr);
      ki = clip(vi);
      if (op == 3'b111) begin
        ma = ar*ar + ai*ai;
        mb = br*br + bi*bi;
        e.r[i*32 +: 32] = (mb > ma) ? b[i*32 +: 32] : a[i*32 +: 32];
      end else if (op == 3'b001 || op == 3'b010 || op[2]) begin
        e.r[i*32 +: 32] = {kr[15:0], ki[15:0]};
        e.s[i] = kr[16] | ki[16];
      end
    end
    return e;
  endfunction

  // scoreboard: sampled on the falling edge, all inputs change just after the rising edge
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst) begin
      q.delete();
      sticky_m = '0;
      chk("rst_out_valid", out_valid, 0);
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      chk("sat_sticky", sat_sticky, sticky_m);
      if (clr_sat) sticky_m = '0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream_result", result, e.r);
          chk("stream_sat", sat, e.s);
          chk("stream_illegal", illegal_op, e.ill);
          sticky_m |= e.s;
        end
      end
      if (in_valid && in_ready) q.push_back(model(opcode, operand_a, operand_b, operand_c));
    end
  end

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (!rand_rdy) out_ready = 1;
      else if (stall > 0) begin out_ready = 0; stall--; end
      else if ($urandom_range(0, 3) == 0) begin stall = $urandom_range(0, 5); out_ready = 0; end
      else out_ready = 1;
    end
  end

  task automatic send(input logic [2:0] op, input logic [127:0] a, b, c);
    int n = 0;
    opcode = op; operand_a = a; operand_b = b; operand_c = c; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic directed(input string nm, input logic [2:0] op, input logic [31:0] a, b, c, r,
                          input bit es, input bit ei);
    exp_t m;
    int n;
    m = model(op, {4{a}}, {4{b}}, {4{c}});
    chk({nm, "_model"}, m.r, {4{r}});
    send(op, {4{a}}, {4{b}}, {4{c}});
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_result"}, result, {4{r}});
    chk({nm, "_sat"}, sat, {4{es}});
    chk({nm, "_illegal"}, illegal_op, ei);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int n, seen;
    rst = 1; in_valid = 0; clr_sat = 0; opcode = '0;
    operand_a = '0; operand_b = '0; operand_c = '0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_result", result, 0);
    chk("reset_sticky", sat_sticky, 0);
    chk("reset_illegal", illegal_op, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    directed("mul",       3'b100, 32'h0180_0080, 32'h0200_ff00, 32'h0, 32'h0380_ff80, 0, 0);
    directed("rnd_up",    3'b100, 32'h0001_0000, 32'h0080_0000, 32'h0, 32'h0001_0000, 0, 0);
    directed("rnd_neg",   3'b100, 32'hffff_0000, 32'h0080_0000, 32'h0, 32'h0000_0000, 0, 0);
    directed("add_sat",   3'b001, 32'h7000_9000, 32'h2000_a000, 32'h0, 32'h7fff_8000, 1, 0);
    directed("max_tie",   3'b111, 32'h0003_0004, 32'h0000_0005, 32'h0, 32'h0003_0004, 0, 0);
    directed("max_b",     3'b111, 32'h0001_0001, 32'h0000_fffe, 32'h0, 32'h0000_fffe, 0, 0);
    directed("muladd",    3'b101, 32'h0100_0000, 32'h0100_0000, 32'h0010_0020, 32'h0110_0020, 0, 0);
    directed("mulsub",    3'b110, 32'h0100_0000, 32'h0100_0000, 32'h0010_0020, 32'h00f0_ffe0, 0, 0);
    directed("sub_sat",   3'b010, 32'h8000_0000, 32'h0001_0000, 32'h0, 32'h8000_0000, 1, 0);
    directed("illegal0",  3'b000, 32'h1234_5678, 32'h1111_2222, 32'h0, 32'h0, 0, 1);
    directed("illegal3",  3'b011, 32'h1234_5678, 32'h1111_2222, 32'h0, 32'h0, 0, 1);

    chk("sticky_hold", sat_sticky, 4'hf);
    clr_sat = 1; @(posedge clk); #1 clr_sat = 0;
    chk("sticky_clear", sat_sticky, 4'h0);

    send(3'b001, {4{32'h7000_9000}}, {4{32'h2000_a000}}, '0);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    clr_sat = 1; @(posedge clk); #1 clr_sat = 0;
    chk("sticky_clr_coincide", sat_sticky, 4'hf);

    rand_rdy = 1;
    for (int i = 0; i < 32; i++) begin
      send(3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin in_valid = 0; @(posedge clk); #1; end
    end
    in_valid = 0;
    drain();
    rand_rdy = 0;
    repeat (8) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++)
      send(3'b001, {4{32'h0001_0002}}, {4{32'h0003_0004}}, '0);
    rst = 1; in_valid = 0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_result", result, 0);
    chk("flush_sticky", sat_sticky, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; seen += int'(out_valid); end
    chk("no_stale_beat", seen, 0);

    directed("post_rst",  3'b100, 32'h0180_0080, 32'h0200_ff00, 32'h0, 32'h0380_ff80, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
